fsm_4: RTL and testbench

- Self-running traffic-light controller: vehicle lamp sequence plus a pedestrian-walk phase.
- Free-runs with no request inputs.
- Cycles through five timed phases, each shown on a one-hot 5-bit `light` bus.
- Raises `on` while pedestrians may cross; top-level driver for lamp outputs in the intersection subsystem.

---
 rtl/fsm_4_pkg.sv | 47 ++++
 rtl/fsm_4_timer.sv | 27 ++
 rtl/fsm_4.sv | 70 +++++++
 tb/tb_fsm_4.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fsm_4_pkg.sv
// Shared phase encodings, default dwell times and the phase-to-dwell lookup
// for the fsm_4 traffic-light controller.
package fsm_4_pkg;

   localparam int unsigned LIGHT_W = 5;

   localparam logic [LIGHT_W-1:0] LIGHT_GREEN      = 5'b00001;
   localparam logic [LIGHT_W-1:0] LIGHT_YELLOW     = 5'b00010;
   localparam logic [LIGHT_W-1:0] LIGHT_RED        = 5'b00100;
   localparam logic [LIGHT_W-1:0] LIGHT_PED_WALK   = 5'b01000;
   localparam logic [LIGHT_W-1:0] LIGHT_RED_YELLOW = 5'b10000;

   localparam int unsigned DEF_T_GREEN  = 20;
   localparam int unsigned DEF_T_YELLOW = 5;
   localparam int unsigned DEF_T_RED    = 5;
   localparam int unsigned DEF_T_PED    = 15;
   localparam int unsigned DEF_T_RY     = 3;
   localparam int unsigned DEF_CNT_W    = 8;

   typedef enum logic [LIGHT_W-1:0] {
      PH_GREEN      = LIGHT_GREEN,
      PH_YELLOW     = LIGHT_YELLOW,
      PH_RED        = LIGHT_RED,
      PH_PED_WALK   = LIGHT_PED_WALK,
      PH_RED_YELLOW = LIGHT_RED_YELLOW
   } phase_e;

   // Dwell for a phase; a corrupted phase code falls back to the green dwell.
   function automatic int unsigned phase_dwell(
      input phase_e      p,
      input int unsigned t_green,
      input int unsigned t_yellow,
      input int unsigned t_red,
      input int unsigned t_ped,
      input int unsigned t_ry
   );
      case (p)
         PH_GREEN:      return t_green;
         PH_YELLOW:     return t_yellow;
         PH_RED:        return t_red;
         PH_PED_WALK:   return t_ped;
         PH_RED_YELLOW: return t_ry;
         default:       return t_green;
      endcase
   endfunction

endpackage

// File: rtl/fsm_4_timer.sv
// Loadable dwell counter: counts up from zero, flags the final cycle of a
// dwell of i_limit cycles. A limit of 2**CNT_W arrives as 0 and wraps correctly.
module fsm_4_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic [CNT_W-1:0] i_limit,
   output logic             o_done_c
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_done_c = (r_cnt == (i_limit - CNT_W'(1)));

endmodule

// File: rtl/fsm_4.sv
// Free-running traffic-light controller: five timed one-hot phases with a
// registered pedestrian-walk enable that tracks the walk phase exactly.
module fsm_4
   import fsm_4_pkg::*;
#(
   parameter int unsigned T_GREEN  = DEF_T_GREEN,
   parameter int unsigned T_YELLOW = DEF_T_YELLOW,
   parameter int unsigned T_RED    = DEF_T_RED,
   parameter int unsigned T_PED    = DEF_T_PED,
   parameter int unsigned T_RY     = DEF_T_RY,
   parameter int unsigned CNT_W    = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   output logic [LIGHT_W-1:0] light,
   output logic               on
);

   phase_e           r_state;
   phase_e           w_next;
   logic             r_on;
   logic             w_next_on;
   logic             w_clr;
   logic             w_done;
   logic [CNT_W-1:0] w_limit;

   assign w_limit = CNT_W'(phase_dwell(r_state, T_GREEN, T_YELLOW, T_RED, T_PED, T_RY));

   fsm_4_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_clr),
      .i_limit  (w_limit),
      .o_done_c (w_done)
   );

   // Next phase and walk enable; any non-legal code recovers to green.
   always_comb begin
      w_next = r_state;
      w_clr  = 1'b0;
      case (r_state)
         PH_GREEN:      if (w_done) begin w_next = PH_YELLOW;     w_clr = 1'b1; end
         PH_YELLOW:     if (w_done) begin w_next = PH_RED;        w_clr = 1'b1; end
         PH_RED:        if (w_done) begin w_next = PH_PED_WALK;   w_clr = 1'b1; end
         PH_PED_WALK:   if (w_done) begin w_next = PH_RED_YELLOW; w_clr = 1'b1; end
         PH_RED_YELLOW: if (w_done) begin w_next = PH_GREEN;      w_clr = 1'b1; end
         default: begin
            w_next = PH_GREEN;
            w_clr  = 1'b1;
         end
      endcase
      w_next_on = (w_next == PH_PED_WALK);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= PH_GREEN;
         r_on    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_on    <= w_next_on;
      end
   end

   assign light = r_state;
   assign on    = r_on;

endmodule

// File: tb/tb_fsm_4.sv
// Directed bench for fsm_4: default timing instance plus an all-dwell-of-one
// instance, both checked every cycle against a hand-derived timeline.
module tb_fsm_4;
   import fsm_4_pkg::*;

   logic       clk;
   logic       rst;
   logic [4:0] light0, light1;
   logic       on0, on1;

   int n_cmp;
   int n_err;
   int c0, c1;
   bit forced_recover;

   fsm_4 u_dut0 (
      .clk   (clk),
      .rst   (rst),
      .light (light0),
      .on    (on0)
   );

   fsm_4 #(
      .T_GREEN  (1),
      .T_YELLOW (1),
      .T_RED    (1),
      .T_PED    (1),
      .T_RY     (1),
      .CNT_W    (8)
   ) u_dut1 (
      .clk   (clk),
      .rst   (rst),
      .light (light1),
      .on    (on1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Default timeline: green 0-19, yellow 20-24, red 25-29, walk 30-44, red+yellow 45-47.
   function automatic logic [4:0] exp_light0(input int c);
      int m;
      m = c % 48;
      if (m < 20)      return 5'b00001;
      else if (m < 25) return 5'b00010;
      else if (m < 30) return 5'b00100;
      else if (m < 45) return 5'b01000;
      else             return 5'b10000;
   endfunction

   function automatic logic [4:0] exp_light1(input int c);
      logic [4:0] codes [5];
      codes[0] = 5'b00001;
      codes[1] = 5'b00010;
      codes[2] = 5'b00100;
      codes[3] = 5'b01000;
      codes[4] = 5'b10000;
      return codes[c % 5];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h (c0=%0d c1=%0d)", tag, obs, exp, c0, c1);
      end
   endtask

   // Advance one edge, update the cycle indices, check both instances.
   task automatic tick();
      logic [4:0] e0, e1;
      @(posedge clk);
      #1;
      if (!rst) begin
         c0 = 0;
         c1 = 0;
      end else begin
         c0 = forced_recover ? 0 : c0 + 1;
         c1 = c1 + 1;
      end
      forced_recover = 1'b0;
      e0 = exp_light0(c0);
      e1 = exp_light1(c1);
      chk("light0", 32'(light0), 32'(e0));
      chk("on0", 32'(on0), 32'(e0 == 5'b01000));
      chk("onehot0", 32'($onehot(light0)), 32'd1);
      chk("light1", 32'(light1), 32'(e1));
      chk("on1", 32'(on1), 32'(e1 == 5'b01000));
   endtask

   initial begin
      int         on_cnt;
      int         green_entries;
      logic [4:0] prev;
      logic [4:0] bad;

      n_cmp = 0;
      n_err = 0;
      c0 = 0;
      c1 = 0;
      forced_recover = 1'b0;
      rst = 1'b0;

      // Two reset edges: green, walk off.
      tick();
      tick();
      chk("reset_light", 32'(light0), 32'h01);
      chk("reset_on", 32'(on0), 32'h0);
      rst = 1'b1;

      // 200-cycle run (cycles 0..199): four full periods, walk 15 cycles each.
      on_cnt = 0;
      green_entries = 0;
      prev = light0;
      for (int i = 1; i < 200; i++) begin
         tick();
         if (on0) on_cnt++;
         if (light0 == 5'b00001 && prev == 5'b10000) green_entries++;
         prev = light0;
         if (c0 == 20) chk("edge_yellow", 32'(light0), 32'h02);
         if (c0 == 25) chk("edge_red", 32'(light0), 32'h04);
         if (c0 == 30) chk("edge_walk_on", 32'(on0), 32'h1);
         if (c0 == 45) chk("edge_ry_on", 32'(on0), 32'h0);
         if (c0 == 48) chk("edge_green2", 32'(light0), 32'h01);
      end
      chk("walk_cycles_200", 32'(on_cnt), 32'd60);
      chk("periods_200", 32'(green_entries), 32'd4);

      // Reset in the middle of the walk phase (cycle 227 = 35 mod 48).
      while (c0 < 227) tick();
      chk("pre_reset_walk", 32'(light0), 32'h08);
      rst = 1'b0;
      tick();
      chk("midreset_light", 32'(light0), 32'h01);
      chk("midreset_on", 32'(on0), 32'h0);
      rst = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      chk("green_full_after_reset", 32'(light0), 32'h02);

      // Corrupt the state while walking, then let it recover.
      while (c0 < 35) tick();
      bad = 5'b00011;
      force u_dut0.r_state = phase_e'(bad);
      #1;
      chk("forced_light", 32'(light0), 32'h03);
      release u_dut0.r_state;
      forced_recover = 1'b1;
      tick();
      chk("recover_light", 32'(light0), 32'h01);
      chk("recover_on", 32'(on0), 32'h0);
      for (int i = 0; i < 48; i++) tick();
      chk("resume_period", 32'(light0), 32'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
